// File: rtl/ray_dispatch.sv
// Ray-march loop controller: injects camera rays, recirculates
// unfinished rays and retires finished ones to the framebuffer.

package ray_dispatch_pkg;
  typedef struct packed {
    logic        [15:0] px;
    logic        [15:0] py;
    logic        [15:0] pz;
    logic signed [19:0] sx;
    logic signed [19:0] sy;
    logic signed [19:0] sz;
    logic        [19:0] pix;
    logic        [3:0]  cnt;
  } ray_t;
endpackage

module ray_dispatch
  import ray_dispatch_pkg::*;
#(
  parameter int          LAT        = 6,
  parameter int          NUM_PIXELS = 76800,
  parameter logic [12:0] SKY_TEX    = 13'h1F00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  output logic               busy,
  output logic               frame_done,
  input  logic               ray_valid,
  output logic               ray_ready,
  input  logic        [15:0] ray_pos_x,
  input  logic        [15:0] ray_pos_y,
  input  logic        [15:0] ray_pos_z,
  input  logic signed [19:0] ray_slope_x,
  input  logic signed [19:0] ray_slope_y,
  input  logic signed [19:0] ray_slope_z,
  input  logic        [19:0] ray_pixel_addr,
  output logic               prepare_flag,
  output logic        [15:0] pp_start_pos_x,
  output logic        [15:0] pp_start_pos_y,
  output logic        [15:0] pp_start_pos_z,
  output logic signed [19:0] pp_ray_slope_x,
  output logic signed [19:0] pp_ray_slope_y,
  output logic signed [19:0] pp_ray_slope_z,
  output logic        [19:0] pp_pixel_addr,
  output logic        [3:0]  pp_block_cnt,
  input  logic        [15:0] pp_end_pos_x,
  input  logic        [15:0] pp_end_pos_y,
  input  logic        [15:0] pp_end_pos_z,
  input  logic        [19:0] pp_ray_slope_out_x,
  input  logic        [19:0] pp_ray_slope_out_y,
  input  logic        [19:0] pp_ray_slope_out_z,
  input  logic        [19:0] pp_pixel_addr_out,
  input  logic        [3:0]  pp_block_cnt_out,
  input  logic               pp_next_en,
  input  logic        [12:0] pp_texture_addr,
  input  logic        [3:0]  hit_block_id,
  output logic               fb_wr_en,
  output logic        [19:0] fb_wr_addr,
  output logic        [12:0] fb_wr_texture_addr,
  output logic               fb_wr_sky
);

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    RUN,
    DRAIN
  } state_t;

  localparam int          PW    = $clog2(LAT + 2);
  localparam logic [16:0] NP    = 17'(NUM_PIXELS);
  localparam logic [PW-1:0] LAT_C = PW'(LAT);

  state_t        state;
  state_t        state_n;
  logic [LAT:0]  slot_v;
  logic [PW-1:0] prep_cnt;
  logic [PW-1:0] inflight;
  logic [16:0]   issued;
  logic [16:0]   retired;

  ray_t pp_q;
  ray_t nxt;
  ray_t ret_ray;
  ray_t cam_ray;
  logic nxt_v;
  logic ret_v;
  logic active;
  logic do_recirc;
  logic do_retire;
  logic do_issue;
  logic room;
  logic sky;

  assign ret_v     = slot_v[LAT];
  assign active    = (state == RUN) || (state == DRAIN);
  assign do_recirc = active && ret_v && !pp_next_en;
  assign do_retire = active && ret_v && pp_next_en;
  assign room      = (state == RUN) && !do_recirc
                   && (issued < NP);
  assign do_issue  = room && ray_valid;
  assign sky       = (hit_block_id == 4'd0);

  assign ray_ready    = room;
  assign prepare_flag = (state == PREP);
  assign busy         = (state != IDLE);
  assign frame_done   = (state == DRAIN)
                      && (retired == NP);

  assign pp_start_pos_x = pp_q.px;
  assign pp_start_pos_y = pp_q.py;
  assign pp_start_pos_z = pp_q.pz;
  assign pp_ray_slope_x = pp_q.sx;
  assign pp_ray_slope_y = pp_q.sy;
  assign pp_ray_slope_z = pp_q.sz;
  assign pp_pixel_addr  = pp_q.pix;
  assign pp_block_cnt   = pp_q.cnt;

  // end position of a returning ray is its next start
  always_comb begin
    ret_ray     = '0;
    ret_ray.px  = pp_end_pos_x;
    ret_ray.py  = pp_end_pos_y;
    ret_ray.pz  = pp_end_pos_z;
    ret_ray.sx  = pp_ray_slope_out_x;
    ret_ray.sy  = pp_ray_slope_out_y;
    ret_ray.sz  = pp_ray_slope_out_z;
    ret_ray.pix = pp_pixel_addr_out;
    ret_ray.cnt = pp_block_cnt_out;
  end

  always_comb begin
    cam_ray     = '0;
    cam_ray.px  = ray_pos_x;
    cam_ray.py  = ray_pos_y;
    cam_ray.pz  = ray_pos_z;
    cam_ray.sx  = ray_slope_x;
    cam_ray.sy  = ray_slope_y;
    cam_ray.sz  = ray_slope_z;
    cam_ray.pix = ray_pixel_addr;
  end

  always_comb begin
    nxt   = '0;
    nxt_v = 1'b0;
    unique case (1'b1)
      do_recirc: begin
        nxt   = ret_ray;
        nxt_v = 1'b1;
      end
      do_issue: begin
        nxt   = cam_ray;
        nxt_v = 1'b1;
      end
      default: begin
        nxt   = '0;
        nxt_v = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:
        if (frame_start) state_n = PREP;
      PREP:
        if (prep_cnt == LAT_C) state_n = RUN;
      RUN:
        if (issued == NP) state_n = DRAIN;
      DRAIN:
        if (retired == NP) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      slot_v <= '0;
      pp_q   <= '0;
    end else begin
      state  <= state_n;
      slot_v <= {slot_v[LAT-1:0], nxt_v};
      pp_q   <= nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb_wr_en           <= 1'b0;
      fb_wr_addr         <= '0;
      fb_wr_texture_addr <= '0;
      fb_wr_sky          <= 1'b0;
    end else begin
      fb_wr_en   <= do_retire;
      fb_wr_sky  <= do_retire && sky;
      fb_wr_addr <= do_retire ? pp_pixel_addr_out
                              : '0;
      if (!do_retire)
        fb_wr_texture_addr <= '0;
      else if (sky)
        fb_wr_texture_addr <= SKY_TEX;
      else
        fb_wr_texture_addr <= pp_texture_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prep_cnt <= '0;
      inflight <= '0;
      issued   <= '0;
      retired  <= '0;
    end else if (state == IDLE && frame_start) begin
      prep_cnt <= '0;
      inflight <= '0;
      issued   <= '0;
      retired  <= '0;
    end else begin
      if (state == PREP)
        prep_cnt <= prep_cnt + 1'b1;
      if (do_issue)
        issued <= issued + 17'd1;
      if (do_retire && retired != NP)
        retired <= retired + 17'd1;
      // a slot reused in the cycle it retires nets to zero
      unique case ({do_issue, do_retire})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_dispatch.sv
// Bench for ray_dispatch: emulated march stage, per-ray
// closed-form reference and framebuffer scoreboard.

module tb_ray_dispatch;

  localparam int LAT = 6;
  localparam int NP  = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               frame_start;
  logic               busy;
  logic               frame_done;
  logic               ray_valid;
  logic               ray_ready;
  logic        [15:0] ray_pos_x, ray_pos_y, ray_pos_z;
  logic signed [19:0] ray_slope_x, ray_slope_y, ray_slope_z;
  logic        [19:0] ray_pixel_addr;
  logic               prepare_flag;
  logic        [15:0] pp_start_pos_x, pp_start_pos_y, pp_start_pos_z;
  logic signed [19:0] pp_ray_slope_x, pp_ray_slope_y, pp_ray_slope_z;
  logic        [19:0] pp_pixel_addr;
  logic        [3:0]  pp_block_cnt;
  logic        [15:0] pp_end_pos_x, pp_end_pos_y, pp_end_pos_z;
  logic        [19:0] pp_ray_slope_out_x, pp_ray_slope_out_y;
  logic        [19:0] pp_ray_slope_out_z;
  logic        [19:0] pp_pixel_addr_out;
  logic        [3:0]  pp_block_cnt_out;
  logic               pp_next_en;
  logic        [12:0] pp_texture_addr;
  logic        [3:0]  hit_block_id;
  logic               fb_wr_en;
  logic        [19:0] fb_wr_addr;
  logic        [12:0] fb_wr_texture_addr;
  logic               fb_wr_sky;

  always #5 clk = ~clk;

  ray_dispatch #(
    .LAT(LAT),
    .NUM_PIXELS(NP),
    .SKY_TEX(13'h1F00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .busy(busy),
    .frame_done(frame_done),
    .ray_valid(ray_valid),
    .ray_ready(ray_ready),
    .ray_pos_x(ray_pos_x),
    .ray_pos_y(ray_pos_y),
    .ray_pos_z(ray_pos_z),
    .ray_slope_x(ray_slope_x),
    .ray_slope_y(ray_slope_y),
    .ray_slope_z(ray_slope_z),
    .ray_pixel_addr(ray_pixel_addr),
    .prepare_flag(prepare_flag),
    .pp_start_pos_x(pp_start_pos_x),
    .pp_start_pos_y(pp_start_pos_y),
    .pp_start_pos_z(pp_start_pos_z),
    .pp_ray_slope_x(pp_ray_slope_x),
    .pp_ray_slope_y(pp_ray_slope_y),
    .pp_ray_slope_z(pp_ray_slope_z),
    .pp_pixel_addr(pp_pixel_addr),
    .pp_block_cnt(pp_block_cnt),
    .pp_end_pos_x(pp_end_pos_x),
    .pp_end_pos_y(pp_end_pos_y),
    .pp_end_pos_z(pp_end_pos_z),
    .pp_ray_slope_out_x(pp_ray_slope_out_x),
    .pp_ray_slope_out_y(pp_ray_slope_out_y),
    .pp_ray_slope_out_z(pp_ray_slope_out_z),
    .pp_pixel_addr_out(pp_pixel_addr_out),
    .pp_block_cnt_out(pp_block_cnt_out),
    .pp_next_en(pp_next_en),
    .pp_texture_addr(pp_texture_addr),
    .hit_block_id(hit_block_id),
    .fb_wr_en(fb_wr_en),
    .fb_wr_addr(fb_wr_addr),
    .fb_wr_texture_addr(fb_wr_texture_addr),
    .fb_wr_sky(fb_wr_sky)
  );

  typedef struct {
    logic [15:0] x, y, z;
    logic [19:0] sx, sy, sz, pix;
    logic [3:0]  cnt;
  } snap_t;

  snap_t hist [LAT];

  // per-ray stimulus and expected behaviour
  logic        [19:0] pix [NP];
  logic        [15:0] cx [NP], cy [NP], cz [NP];
  logic        [15:0] dx [NP], dy [NP], dz [NP];
  logic signed [19:0] sx [NP], sy [NP], sz [NP];
  int                 npass [NP];
  logic        [3:0]  hit [NP];
  logic        [12:0] tex [NP];

  bit          seen [NP];
  int          rec_cnt [NP];
  logic [12:0] wr_tex [NP];
  logic        wr_sky [NP];

  int checks = 0;
  int errors = 0;
  int cyc, src_i, acc_idx, valid_pct, inj_cyc;
  int nwr, ndone, done_cyc, last_wr, overlap, stray_prep;
  bit acc, prev_acc, chk_prep, src_on;
  int issue_log [$];

  task automatic load_src();
    if (src_i < NP) begin
      ray_pos_x      = cx[src_i];
      ray_pos_y      = cy[src_i];
      ray_pos_z      = cz[src_i];
      ray_slope_x    = sx[src_i];
      ray_slope_y    = sy[src_i];
      ray_slope_z    = sz[src_i];
      ray_pixel_addr = pix[src_i];
    end
  endtask

  task automatic init_tables(input int maxpass);
    for (int i = 0; i < NP; i++) begin
      pix[i]   = {16'($urandom), 4'(i)};
      cx[i]    = 16'($urandom);
      cy[i]    = 16'($urandom);
      cz[i]    = 16'($urandom);
      dx[i]    = 16'($urandom_range(1, 4095));
      dy[i]    = 16'($urandom_range(1, 4095));
      dz[i]    = 16'($urandom_range(1, 4095));
      sx[i]    = 20'($urandom);
      sy[i]    = 20'($urandom);
      sz[i]    = 20'($urandom);
      npass[i] = $urandom_range(1, maxpass);
      hit[i]   = 4'($urandom_range(0, 3));
      tex[i]   = 13'($urandom);
    end
  endtask

  task automatic tick();
    int          idx;
    logic [15:0] ex, ey, ez;
    logic        es;
    logic [12:0] et;
    snap_t       h;
    @(negedge clk);
    if (prev_acc) begin
      checks++;
      if (pp_pixel_addr !== pix[acc_idx]
          || pp_start_pos_x !== cx[acc_idx]
          || pp_start_pos_y !== cy[acc_idx]
          || pp_start_pos_z !== cz[acc_idx]
          || pp_ray_slope_x !== sx[acc_idx]
          || pp_ray_slope_z !== sz[acc_idx]
          || pp_block_cnt !== 4'd0) begin
        errors++;
        $display("FAIL issue: ray %0d pix %h x %h cnt %0d, required pix %h x %h cnt 0",
                 acc_idx, pp_pixel_addr, pp_start_pos_x,
                 pp_block_cnt, pix[acc_idx], cx[acc_idx]);
      end
    end else if (pp_block_cnt != 4'd0) begin
      idx = int'(pp_pixel_addr[3:0]);
      ex  = cx[idx] + dx[idx] * 16'(pp_block_cnt);
      ey  = cy[idx] + dy[idx] * 16'(pp_block_cnt);
      ez  = cz[idx] + dz[idx] * 16'(pp_block_cnt);
      rec_cnt[idx]++;
      checks++;
      if (pp_pixel_addr !== pix[idx]
          || pp_start_pos_x !== ex
          || pp_start_pos_y !== ey
          || pp_start_pos_z !== ez
          || pp_ray_slope_y !== sy[idx]) begin
        errors++;
        $display("FAIL recirc: pix %h pass %0d pos %h/%h/%h, required pix %h pos %h/%h/%h",
                 pp_pixel_addr, pp_block_cnt, pp_start_pos_x,
                 pp_start_pos_y, pp_start_pos_z, pix[idx],
                 ex, ey, ez);
      end
    end
    if (fb_wr_en) begin
      idx = int'(fb_wr_addr[3:0]);
      es  = (hit[idx] == 4'd0);
      et  = es ? 13'h1F00 : tex[idx];
      checks++;
      if (fb_wr_addr !== pix[idx] || fb_wr_texture_addr !== et
          || fb_wr_sky !== es || seen[idx]
          || rec_cnt[idx] != npass[idx] - 1) begin
        errors++;
        $display("FAIL fb_write: addr %h tex %h sky %b dup %0d passes %0d, required addr %h tex %h sky %b passes %0d",
                 fb_wr_addr, fb_wr_texture_addr, fb_wr_sky,
                 seen[idx], rec_cnt[idx], pix[idx], et, es,
                 npass[idx] - 1);
      end
      seen[idx]   = 1'b1;
      wr_tex[idx] = fb_wr_texture_addr;
      wr_sky[idx] = fb_wr_sky;
      nwr++;
      last_wr = cyc;
      if (prev_acc) overlap++;
    end
    if (frame_done) begin
      ndone++;
      done_cyc = cyc;
    end
    if (ndone > 0 && cyc == done_cyc + 1) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_after_done: busy %b, required 0", busy);
      end
    end
    if (chk_prep && cyc >= 1 && cyc <= 8) begin
      checks++;
      if (prepare_flag !== (cyc <= 7) || busy !== 1'b1
          || ray_ready !== (cyc == 8)) begin
        errors++;
        $display("FAIL prep_cycle%0d: prep %b busy %b ready %b, required prep %b busy 1 ready %b",
                 cyc, prepare_flag, busy, ray_ready,
                 cyc <= 7, cyc == 8);
      end
    end
    if (cyc > 8 && prepare_flag) stray_prep++;
    acc = ray_valid && ray_ready;
    if (acc) begin
      issue_log.push_back(cyc);
      acc_idx = src_i;
    end
    prev_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) src_i++;
    frame_start = (cyc == inj_cyc);
    // march stage: fixed per-ray step, finishes after npass passes
    h   = hist[LAT-1];
    idx = int'(h.pix[3:0]);
    pp_end_pos_x       = h.x + dx[idx];
    pp_end_pos_y       = h.y + dy[idx];
    pp_end_pos_z       = h.z + dz[idx];
    pp_ray_slope_out_x = h.sx;
    pp_ray_slope_out_y = h.sy;
    pp_ray_slope_out_z = h.sz;
    pp_pixel_addr_out  = h.pix;
    pp_block_cnt_out   = h.cnt + 4'd1;
    pp_next_en         = (int'(h.cnt) + 1 >= npass[idx]);
    hit_block_id       = hit[idx];
    pp_texture_addr    = tex[idx];
    for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0].x   = pp_start_pos_x;
    hist[0].y   = pp_start_pos_y;
    hist[0].z   = pp_start_pos_z;
    hist[0].sx  = pp_ray_slope_x;
    hist[0].sy  = pp_ray_slope_y;
    hist[0].sz  = pp_ray_slope_z;
    hist[0].pix = pp_pixel_addr;
    hist[0].cnt = pp_block_cnt;
    if (acc || !ray_valid) begin
      if (src_on && src_i < NP
          && int'($urandom_range(99)) < valid_pct) begin
        ray_valid = 1'b1;
        load_src();
      end else begin
        ray_valid = 1'b0;
      end
    end
  endtask

  task automatic start_frame(input int pct, input int inj,
                             input bit prep_chk);
    src_i      = 0;
    nwr        = 0;
    ndone      = 0;
    done_cyc   = -10;
    last_wr    = -10;
    overlap    = 0;
    stray_prep = 0;
    prev_acc   = 1'b0;
    valid_pct  = pct;
    inj_cyc    = inj;
    chk_prep   = prep_chk;
    src_on     = 1'b1;
    issue_log.delete();
    for (int i = 0; i < NP; i++) begin
      seen[i]    = 1'b0;
      rec_cnt[i] = 0;
    end
    ray_valid = (int'($urandom_range(99)) < pct);
    load_src();
    cyc         = 0;
    frame_start = 1'b1;
  endtask

  task automatic run_frame(input int pct, input int inj,
                           input bit prep_chk);
    start_frame(pct, inj, prep_chk);
    for (int t = 0; t < 3000; t++) begin
      tick();
      if (ndone > 0 && cyc > done_cyc + 1) break;
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL frame_done_count: %0d, required 1", ndone);
    end
    checks++;
    if (nwr !== NP) begin
      errors++;
      $display("FAIL write_count: %0d, required %0d", nwr, NP);
    end
    checks++;
    if (done_cyc < last_wr || done_cyc > last_wr + 1) begin
      errors++;
      $display("FAIL done_timing: done cycle %0d, last write %0d",
               done_cyc, last_wr);
    end
    checks++;
    if (stray_prep != 0) begin
      errors++;
      $display("FAIL restart_while_busy: prepare_flag %0d cycles, required 0",
               stray_prep);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, ray_ready, prepare_flag, frame_done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/ready/prep/done %b%b%b%b, required 0000",
               busy, ray_ready, prepare_flag, frame_done);
    end
    checks++;
    if (fb_wr_en !== 1'b0 || fb_wr_addr !== 20'd0
        || fb_wr_texture_addr !== 13'd0 || fb_wr_sky !== 1'b0) begin
      errors++;
      $display("FAIL reset_fb: en %b addr %h tex %h, required all 0",
               fb_wr_en, fb_wr_addr, fb_wr_texture_addr);
    end
    checks++;
    if (pp_pixel_addr !== 20'd0 || pp_block_cnt !== 4'd0
        || pp_start_pos_x !== 16'd0 || pp_ray_slope_x !== 20'sd0) begin
      errors++;
      $display("FAIL reset_pp: pix %h cnt %0d x %h, required all 0",
               pp_pixel_addr, pp_block_cnt, pp_start_pos_x);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    init_tables(1);
    run_frame(100, 0, 1'b1);
    checks++;
    if (issue_log.size() != NP) begin
      errors++;
      $display("FAIL b2b_issues: %0d, required %0d",
               issue_log.size(), NP);
    end else begin
      for (int i = 0; i < NP; i++) begin
        checks++;
        if (issue_log[i] != 8 + i) begin
          errors++;
          $display("FAIL b2b_issue_cycle%0d: %0d, required %0d",
                   i, issue_log[i], 8 + i);
        end
      end
    end
    checks++;
    if (overlap != 9) begin
      errors++;
      $display("FAIL b2b_write_with_issue: %0d cycles, required 9",
               overlap);
    end
  endtask

  task automatic test_recirculate();
    init_tables(4);
    npass[0] = 4;
    hit[0]   = 4'd5;
    tex[0]   = 13'h123;
    hit[1]   = 4'd0;
    run_frame(70, 0, 1'b0);
    checks++;
    if (rec_cnt[0] != 3) begin
      errors++;
      $display("FAIL recirc_passes: %0d, required 3", rec_cnt[0]);
    end
    checks++;
    if (wr_tex[0] !== 13'h123 || wr_sky[0] !== 1'b0) begin
      errors++;
      $display("FAIL hit_write: tex %h sky %b, required 123 0",
               wr_tex[0], wr_sky[0]);
    end
    checks++;
    if (wr_tex[1] !== 13'h1F00 || wr_sky[1] !== 1'b1) begin
      errors++;
      $display("FAIL sky_write: tex %h sky %b, required 1f00 1",
               wr_tex[1], wr_sky[1]);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      init_tables(4);
      run_frame($urandom_range(30, 100), (f == 0) ? 4 : 12,
                1'b0);
    end
  endtask

  task automatic test_reset_mid();
    init_tables(3);
    start_frame(100, 0, 1'b0);
    repeat (20) tick();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, ray_ready, prepare_flag, frame_done} !== 4'b0
        || fb_wr_en !== 1'b0 || pp_pixel_addr !== 20'd0
        || pp_block_cnt !== 4'd0 || pp_start_pos_y !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy %b ready %b wr %b pix %h, required all 0",
               busy, ray_ready, fb_wr_en, pp_pixel_addr);
    end
    prev_acc = 1'b0;
    ndone    = 0;
    nwr      = 0;
    repeat (40) tick();
    checks++;
    if (ndone != 0 || nwr != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: done %0d writes %0d busy %b, required 0 0 0",
               ndone, nwr, busy);
    end
  endtask

  initial begin
    frame_start        = 1'b0;
    ray_valid          = 1'b0;
    ray_pos_x          = '0;
    ray_pos_y          = '0;
    ray_pos_z          = '0;
    ray_slope_x        = '0;
    ray_slope_y        = '0;
    ray_slope_z        = '0;
    ray_pixel_addr     = '0;
    pp_end_pos_x       = '0;
    pp_end_pos_y       = '0;
    pp_end_pos_z       = '0;
    pp_ray_slope_out_x = '0;
    pp_ray_slope_out_y = '0;
    pp_ray_slope_out_z = '0;
    pp_pixel_addr_out  = '0;
    pp_block_cnt_out   = '0;
    pp_next_en         = 1'b0;
    pp_texture_addr    = '0;
    hit_block_id       = '0;
    src_on             = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      hist[i].x   = '0;
      hist[i].y   = '0;
      hist[i].z   = '0;
      hist[i].sx  = '0;
      hist[i].sy  = '0;
      hist[i].sz  = '0;
      hist[i].pix = '0;
      hist[i].cnt = '0;
    end
    init_tables(1);
    test_reset();
    test_back_to_back();
    test_recirculate();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ray_dispatch.md
Name: ray_dispatch

Overview:
- Loop controller at the input/output end of the ray-march stage pipeline. Owns all ray slots circulating through that stage.
- Injects new camera rays and recirculates unfinished rays, feeding each ray's end position back as its next start position.
- Retires rays that the pipeline flags as finished. Each retirement produces one framebuffer write.
- Runs one frame per frame_start pulse and signals frame_done once every pixel has been written.

Parameters:
LAT, 6, register depth of the march stage (input to next_en/end_pos)
NUM_PIXELS, 76800, rays per frame (320x240)
SKY_TEX, 13'h1F00, texture address written when a ray ends without hitting a block

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
frame_start  in  1  one-cycle pulse; starts a frame; ignored unless IDLE
busy  out  1  high in PREP/RUN/DRAIN
frame_done  out  1  one-cycle pulse after the last retirement
ray_valid  in  1  camera ray available
ray_ready  out  1  new ray accepted this cycle
ray_pos_x/y/z  in  16 each  camera start position (Q9.7)
ray_slope_x/y/z  in  20 each signed  ray slope
ray_pixel_addr  in  20  target pixel
prepare_flag  out  1  to march stage; high only in PREP
pp_start_pos_x/y/z  out  16 each  slot start position
pp_ray_slope_x/y/z  out  20 each signed  slot slope
pp_pixel_addr  out  20  slot pixel
pp_block_cnt  out  4  slot step count
pp_end_pos_x/y/z  in  16 each  returned end position
pp_ray_slope_out_x/y/z  in  20 each  returned slope
pp_pixel_addr_out  in  20  returned pixel
pp_block_cnt_out  in  4  returned step count
pp_next_en  in  1  returned ray finished
pp_texture_addr  in  13  returned texture address
hit_block_id  in  4  block id at the returned ray's end cell; 0 = air
fb_wr_en  out  1  framebuffer write strobe
fb_wr_addr  out  20  pixel address
fb_wr_texture_addr  out  13  texel address, or SKY_TEX
fb_wr_sky  out  1  ray ended with no block hit

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - state=IDLE
  - all pp_* outputs, fb_* outputs, ray_ready, prepare_flag, busy and frame_done to 0
  - slot valid ring and all counters cleared
- Reset mid-frame abandons the frame; no frame_done is produced.
- pp_* outputs are registered, so loop round-trip = LAT+1 cycles = LAT+1 slots.
- slot_v ring: LAT+1 bits shifting every cycle, tagging the slot currently returning.
- FSM states:
  - IDLE: on frame_start go to PREP; clear issued, retired and inflight; prep_cnt=0.
  - PREP: prepare_flag=1 for exactly LAT+1 cycles; slot_v forced 0; no issue, no fb write. Then go to RUN.
  - RUN: per cycle, evaluate the returning slot ret_v=slot_v[tail]:
    - ret_v=1 and pp_next_en=0 → recirculate:
      - pp_start_pos ← pp_end_pos
      - pp_ray_slope ← pp_ray_slope_out
      - pp_pixel_addr ← pp_pixel_addr_out
      - pp_block_cnt ← pp_block_cnt_out
      - slot_v=1; ray_ready=0
    - ret_v=1 and pp_next_en=1 → retire:
      - fb_wr_en=1, fb_wr_addr=pp_pixel_addr_out
      - fb_wr_sky=(hit_block_id==0)
      - fb_wr_texture_addr = fb_wr_sky ? SKY_TEX : pp_texture_addr
      - slot is now free this same cycle.
    - Free slot (ret_v=0, or just retired):
      - ray_ready = (issued<NUM_PIXELS)
      - on ray_valid&&ray_ready, load ray_* into pp_*, pp_block_cnt=0, slot_v=1
      - otherwise pp_* are zeroed and slot_v=0 (bubble).
    - When issued reaches NUM_PIXELS, go to DRAIN.
  - DRAIN: recirculate/retire exactly as RUN; no issue (ray_ready=0). When retired==NUM_PIXELS, pulse frame_done for 1 cycle and go to IDLE.
- Counters:
  - issued/retired: 17 bits, saturate at NUM_PIXELS.
  - inflight: retire+issue in the same cycle leaves it unchanged; never exceeds LAT+1.
- frame_start while busy is ignored.
- ray_valid while not ray_ready is held by the source; no data is lost.
- fb_wr_en is a single-cycle strobe per retirement. Exactly NUM_PIXELS strobes occur per frame.

Test Plan:
- Reset then frame_start, ray_valid held 1 → prepare_flag high cycles 1..7; first ray_ready on cycle 8; busy=1 from cycle 1.
- One ray with pp_next_en=0 for 3 passes, then 1, hit_block_id=5, pp_texture_addr=0x123 → pp_start_pos equals prior pp_end_pos on each pass; one write with fb_wr_addr=that ray's pixel, texture 0x123, sky=0.
- Ray retires with hit_block_id=0 → fb_wr_sky=1, fb_wr_texture_addr=0x1F00.
- NUM_PIXELS=16, all rays finish after 1 pass → 16 fb_wr_en strobes with distinct addresses; frame_done pulse once; busy low the next cycle.
- Retire and new ray_valid in the same slot → write and issue in the same cycle; inflight unchanged; no bubble.
- rst_n=0 mid-RUN → next cycle all outputs 0, state IDLE; no frame_done.
